// File: rtl/regfile_scoreboard_pkg.sv
// Shared parameters and helpers for the register file with pending-write scoreboard.
// Holds the default geometry, the counter width derivation and the port-slice helper.
package regfile_scoreboard_pkg;

  localparam int unsigned DefDataW      = 32;
  localparam int unsigned DefAddrW      = 5;
  localparam int unsigned DefNumRead    = 2;
  localparam int unsigned DefMaxPending = 3;

  // Counter must hold 0..max_pending inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_pending);
    return (max_pending < 1) ? 1 : $clog2(max_pending + 1);
  endfunction

  // LSB of port `port` in a flat bus of `width`-bit fields.
  function automatic int unsigned port_lsb(input int unsigned port, input int unsigned width);
    return port * width;
  endfunction

endpackage

// File: rtl/scoreboard_cnt.sv
// One saturating up/down reservation counter; clr wins, inc+dec together hold the value.
module scoreboard_cnt #(
  parameter int unsigned CNT_W       = 2,
  parameter int unsigned MAX_PENDING = 3
) (
  input  logic             SYS_clk,
  input  logic             SYS_reset,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(MAX_PENDING);

  logic [CNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !dec && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + 1'b1;
    end else if (dec && !inc && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(negedge SYS_clk or posedge SYS_reset) begin
    if (SYS_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with write-through bypass and per-register pending-write counters.
// Decode reserves destinations on issue, writeback releases them; RAW and full-counter hazards stall.
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int unsigned DATA_W      = DefDataW,
  parameter int unsigned ADDR_W      = DefAddrW,
  parameter int unsigned NUM_READ    = DefNumRead,
  parameter int unsigned MAX_PENDING = DefMaxPending
) (
  input  logic                         SYS_clk,
  input  logic                         SYS_reset,
  input  logic [NUM_READ*ADDR_W-1:0]   rd_addr,
  input  logic [NUM_READ-1:0]          rd_used,
  output logic [NUM_READ*DATA_W-1:0]   rd_data,
  output logic [NUM_READ-1:0]          rd_busy,
  input  logic                         iss_valid,
  input  logic [ADDR_W-1:0]            iss_dest,
  output logic                         iss_accept,
  output logic                         stall,
  input  logic                         wr_en,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic [DATA_W-1:0]            wr_data,
  input  logic                         flush,
  input  logic [ADDR_W-1:0]            dbg_addr,
  output logic [DATA_W-1:0]            dbg_data,
  output logic                         busy_any
);

  localparam int unsigned     NumRegs = 2 ** ADDR_W;
  localparam int unsigned     CNT_W   = cnt_width(MAX_PENDING);
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(MAX_PENDING);
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic [DATA_W-1:0]              mem_q [NumRegs];
  logic [NumRegs-1:0][CNT_W-1:0]  cnt;
  logic [NumRegs-1:1]             cnt_inc;
  logic [NumRegs-1:1]             cnt_dec;
  logic                           rd_hazard;
  logic                           dest_full;
  logic                           hazard;

  // Register 0 is never reserved, so it has no counter.
  assign cnt[0] = '0;

  for (genvar r = 1; r < NumRegs; r++) begin : g_cnt
    assign cnt_inc[r] = iss_accept && (iss_dest == ADDR_W'(r));
    assign cnt_dec[r] = wr_en && (wr_addr == ADDR_W'(r));

    scoreboard_cnt #(
      .CNT_W       (CNT_W),
      .MAX_PENDING (MAX_PENDING)
    ) u_cnt (
      .SYS_clk   (SYS_clk),
      .SYS_reset (SYS_reset),
      .inc       (cnt_inc[r]),
      .dec       (cnt_dec[r]),
      .clr       (flush),
      .cnt       (cnt[r])
    );
  end

  for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              wr_hit;
    logic [CNT_W-1:0]  pend;

    assign addr   = rd_addr[port_lsb(i, ADDR_W) +: ADDR_W];
    assign wr_hit = wr_en && (wr_addr == addr) && (addr != '0);
    assign pend   = cnt[addr];

    assign rd_data[port_lsb(i, DATA_W) +: DATA_W] =
        (addr == '0) ? '0 : (wr_hit ? wr_data : mem_q[addr]);

    // A single outstanding write that lands this cycle is satisfied by the bypass.
    assign rd_busy[i] = (addr != '0) && ((pend > CntOne) || ((pend == CntOne) && !wr_hit));
  end

  assign rd_hazard = |(rd_used & rd_busy);
  assign dest_full = (iss_dest != '0) && (cnt[iss_dest] == CntMax) &&
                     !(wr_en && (wr_addr == iss_dest));
  assign hazard     = rd_hazard || dest_full;
  assign iss_accept = iss_valid && !hazard;
  assign stall      = iss_valid && hazard;
  assign busy_any   = |cnt;
  assign dbg_data   = mem_q[dbg_addr];

  always_ff @(negedge SYS_clk or posedge SYS_reset) begin
    if (SYS_reset) begin
      for (int unsigned r = 0; r < NumRegs; r++) begin
        mem_q[r] <= '0;
      end
    end else if (wr_en && (wr_addr != '0)) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed vector table, reset-mid-stall sequence and randomized run against a reference model.
module tb_regfile_scoreboard;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NR = 2;
  localparam int unsigned MP = 3;

  logic                 SYS_clk = 1'b0;
  logic                 SYS_reset = 1'b0;
  logic [NR*AW-1:0]     rd_addr;
  logic [NR-1:0]        rd_used;
  logic [NR*DW-1:0]     rd_data;
  logic [NR-1:0]        rd_busy;
  logic                 iss_valid;
  logic [AW-1:0]        iss_dest;
  logic                 iss_accept;
  logic                 stall;
  logic                 wr_en;
  logic [AW-1:0]        wr_addr;
  logic [DW-1:0]        wr_data;
  logic                 flush;
  logic [AW-1:0]        dbg_addr;
  logic [DW-1:0]        dbg_data;
  logic                 busy_any;

  regfile_scoreboard #(
    .DATA_W      (DW),
    .ADDR_W      (AW),
    .NUM_READ    (NR),
    .MAX_PENDING (MP)
  ) dut (
    .SYS_clk    (SYS_clk),
    .SYS_reset  (SYS_reset),
    .rd_addr    (rd_addr),
    .rd_used    (rd_used),
    .rd_data    (rd_data),
    .rd_busy    (rd_busy),
    .iss_valid  (iss_valid),
    .iss_dest   (iss_dest),
    .iss_accept (iss_accept),
    .stall      (stall),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .flush      (flush),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data),
    .busy_any   (busy_any)
  );

  always #5 SYS_clk = ~SYS_clk;

  typedef struct {
    int unsigned a0, a1, used, iv, dest, we, wa, wd, fl, dbg;
    int unsigned e_d0, e_d1, e_busy, e_acc, e_stall, e_dbg, e_any;
  } vec_t;

  int          n_vec = 0;
  int          n_err = 0;
  vec_t        tbl [22];
  logic [31:0] mem_m [32];
  int unsigned cnt_m [32];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    rd_addr   = {AW'(v.a1), AW'(v.a0)};
    rd_used   = NR'(v.used);
    iss_valid = v.iv[0];
    iss_dest  = AW'(v.dest);
    wr_en     = v.we[0];
    wr_addr   = AW'(v.wa);
    wr_data   = DW'(v.wd);
    flush     = v.fl[0];
    dbg_addr  = AW'(v.dbg);
  endtask

  task automatic check_outputs(input string tag, input vec_t v);
    chk({tag, ".rd_data0"}, rd_data[DW-1:0], v.e_d0);
    chk({tag, ".rd_data1"}, rd_data[2*DW-1:DW], v.e_d1);
    chk({tag, ".rd_busy"}, 32'(rd_busy), v.e_busy);
    chk({tag, ".iss_accept"}, 32'(iss_accept), v.e_acc);
    chk({tag, ".stall"}, 32'(stall), v.e_stall);
    chk({tag, ".dbg_data"}, dbg_data, v.e_dbg);
    chk({tag, ".busy_any"}, 32'(busy_any), v.e_any);
  endtask

  // Reference model: expected outputs for the current inputs from the model state.
  function automatic bit m_busy(input int unsigned a, input vec_t v);
    bit hit = v.we[0] && (v.wa == a);
    if (a == 0) return 1'b0;
    return (cnt_m[a] > 1) || ((cnt_m[a] == 1) && !hit);
  endfunction

  function automatic int unsigned m_data(input int unsigned a, input vec_t v);
    if (a == 0) return 0;
    if (v.we[0] && (v.wa == a)) return v.wd;
    return mem_m[a];
  endfunction

  function automatic vec_t model_expect(input vec_t v);
    vec_t r = v;
    bit   b0 = m_busy(v.a0, v);
    bit   b1 = m_busy(v.a1, v);
    bit   haz = (v.used[0] && b0) || (v.used[1] && b1) ||
                ((v.dest != 0) && (cnt_m[v.dest] == MP) && !(v.we[0] && (v.wa == v.dest)));
    r.e_d0    = m_data(v.a0, v);
    r.e_d1    = m_data(v.a1, v);
    r.e_busy  = {30'd0, b1, b0};
    r.e_acc   = (v.iv[0] && !haz) ? 1 : 0;
    r.e_stall = (v.iv[0] && haz) ? 1 : 0;
    r.e_dbg   = mem_m[v.dbg];
    r.e_any   = 0;
    for (int k = 1; k < 32; k++) if (cnt_m[k] != 0) r.e_any = 1;
    return r;
  endfunction

  task automatic model_commit(input vec_t r);
    for (int k = 1; k < 32; k++) begin
      bit inc = (r.e_acc != 0) && (r.dest == k);
      bit dec = r.we[0] && (r.wa == k);
      if (r.fl[0]) cnt_m[k] = 0;
      else if (inc && !dec) cnt_m[k] = cnt_m[k] + 1;
      else if (dec && !inc && cnt_m[k] > 0) cnt_m[k] = cnt_m[k] - 1;
    end
    if (r.we[0] && r.wa != 0) mem_m[r.wa] = r.wd;
  endtask

  initial begin
    vec_t v;
    vec_t r;
    // a0,a1,used,iv,dest,we,wa,wd,fl,dbg | d0,d1,busy,acc,stall,dbg,any
    tbl[0]  = '{0, 31, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{8, 8, 0, 0, 0, 1, 8, 'h1234, 0, 8,  'h1234, 'h1234, 0, 0, 0, 0, 0};
    tbl[2]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 8,  0, 0, 0, 0, 0, 'h1234, 0};
    tbl[3]  = '{0, 0, 0, 1, 8, 0, 0, 0, 0, 8,  0, 0, 0, 1, 0, 'h1234, 0};
    tbl[4]  = '{8, 0, 1, 1, 1, 0, 0, 0, 0, 8,  'h1234, 0, 1, 0, 1, 'h1234, 1};
    tbl[5]  = '{8, 0, 1, 1, 1, 1, 8, 'hABCD, 0, 8,  'hABCD, 0, 0, 1, 0, 'h1234, 1};
    tbl[6]  = '{1, 0, 0, 1, 5, 0, 0, 0, 0, 5,  0, 0, 1, 1, 0, 0, 1};
    tbl[7]  = '{5, 1, 0, 1, 5, 0, 0, 0, 0, 0,  0, 0, 3, 1, 0, 0, 1};
    tbl[8]  = '{5, 0, 0, 1, 5, 0, 0, 0, 0, 0,  0, 0, 1, 1, 0, 0, 1};
    tbl[9]  = '{5, 0, 0, 1, 5, 0, 0, 0, 0, 0,  0, 0, 1, 0, 1, 0, 1};
    tbl[10] = '{5, 0, 0, 1, 5, 1, 5, 'h55, 0, 0,  'h55, 0, 1, 1, 0, 0, 1};
    tbl[11] = '{9, 0, 1, 1, 9, 1, 1, 'h11, 0, 5,  0, 0, 0, 1, 0, 'h55, 1};
    tbl[12] = '{9, 1, 0, 1, 9, 1, 9, 'h99, 0, 0,  'h99, 'h11, 0, 1, 0, 0, 1};
    tbl[13] = '{9, 9, 0, 0, 0, 0, 0, 0, 0, 9,  'h99, 'h99, 3, 0, 0, 'h99, 1};
    tbl[14] = '{0, 9, 1, 1, 0, 0, 0, 0, 0, 0,  0, 'h99, 2, 1, 0, 0, 1};
    tbl[15] = '{0, 0, 0, 1, 0, 1, 0, 'hFFFF, 0, 0,  0, 0, 0, 1, 0, 0, 1};
    tbl[16] = '{0, 0, 0, 1, 3, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 1};
    tbl[17] = '{0, 0, 0, 1, 7, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 1};
    tbl[18] = '{3, 7, 0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 3, 0, 0, 0, 1};
    tbl[19] = '{3, 7, 3, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0};
    tbl[20] = '{3, 0, 0, 0, 0, 1, 3, 'h333, 0, 0,  'h333, 0, 0, 0, 0, 0, 0};
    tbl[21] = '{3, 0, 0, 0, 0, 0, 0, 0, 0, 3,  'h333, 0, 0, 0, 0, 'h333, 0};

    v = '{default: 0};
    drive(v);
    #1 SYS_reset = 1'b1;
    @(negedge SYS_clk);
    #1 SYS_reset = 1'b0;

    for (int i = 0; i < 22; i++) begin
      drive(tbl[i]);
      @(posedge SYS_clk);
      check_outputs($sformatf("dir%0d", i), tbl[i]);
      @(negedge SYS_clk);
      #1;
    end

    // Reserve 4, stall on it, then reset asynchronously in the middle of the stall.
    v = '{default: 0};
    v.iv = 1; v.dest = 4;
    drive(v);
    @(posedge SYS_clk);
    chk("mid.reserve_accept", 32'(iss_accept), 1);
    @(negedge SYS_clk);
    #1;
    v = '{default: 0};
    v.a0 = 4; v.used = 1; v.iv = 1; v.dbg = 8;
    drive(v);
    @(posedge SYS_clk);
    chk("mid.stall_before", 32'(stall), 1);
    #1 SYS_reset = 1'b1;
    #1;
    chk("mid.stall_in_reset", 32'(stall), 0);
    chk("mid.accept_in_reset", 32'(iss_accept), 1);
    chk("mid.busy_in_reset", 32'(rd_busy), 0);
    chk("mid.any_in_reset", 32'(busy_any), 0);
    chk("mid.dbg_in_reset", dbg_data, 0);
    #1 SYS_reset = 1'b0;
    @(negedge SYS_clk);
    #1;
    for (int a = 1; a < 32; a++) begin
      v = '{default: 0};
      v.a0 = a; v.a1 = 32 - a; v.used = 3; v.iv = 1; v.dbg = a;
      drive(v);
      @(posedge SYS_clk);
      chk($sformatf("post_rst.busy%0d", a), 32'(rd_busy), 0);
      chk($sformatf("post_rst.data%0d", a), rd_data[DW-1:0], 0);
      chk($sformatf("post_rst.acc%0d", a), 32'(iss_accept), 1);
      @(negedge SYS_clk);
      #1;
    end
    // The loop above issued dest 0 only; counters are still all clear.

    for (int k = 0; k < 32; k++) begin
      mem_m[k] = '0;
      cnt_m[k] = 0;
    end
    for (int n = 0; n < 400; n++) begin
      v.a0   = $urandom_range(0, 7);
      v.a1   = $urandom_range(0, 7);
      v.used = $urandom_range(0, 3);
      v.iv   = ($urandom_range(0, 9) < 7) ? 1 : 0;
      v.dest = $urandom_range(0, 7);
      v.we   = $urandom_range(0, 1);
      v.wa   = $urandom_range(0, 7);
      v.wd   = $urandom;
      v.fl   = ($urandom_range(0, 39) == 0) ? 1 : 0;
      v.dbg  = $urandom_range(0, 7);
      drive(v);
      r = model_expect(v);
      @(posedge SYS_clk);
      check_outputs($sformatf("rnd%0d", n), r);
      @(negedge SYS_clk);
      model_commit(r);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised register file with write-through bypass and a per-register pending-write scoreboard for the decode stage of the 5-stage pipeline. It replaces the plain two-port register file and gives decode a registered view of in-flight destinations. Decode uses it to stall on RAW hazards instead of relying on hazard-free instruction streams. Writeback writes through it and releases reservations; decode issues through it and reserves destinations.

## Interface
Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register address width; 2**ADDR_W registers
- NUM_READ, 2, number of read ports
- MAX_PENDING, 3, maximum outstanding writes tracked per register

Ports:
- SYS_clk  in  1  clock; all state updates on negedge
- SYS_reset  in  1  reset, asynchronous, active-high
- rd_addr  in  NUM_READ*ADDR_W  source addresses; port i at [i*ADDR_W +: ADDR_W]
- rd_used  in  NUM_READ  port i is a real source for the issuing instruction
- rd_data  out  NUM_READ*DATA_W  read data per port, bypassed
- rd_busy  out  NUM_READ  port i source has a pending write not satisfied this cycle
- iss_valid  in  1  decode presents an instruction
- iss_dest  in  ADDR_W  destination of issuing instruction (0 = no write)
- iss_accept  out  1  instruction issues this cycle
- stall  out  1  iss_valid and not accepted
- wr_en  in  1  writeback write; also releases one reservation of wr_addr
- wr_addr  in  ADDR_W  writeback address
- wr_data  in  DATA_W  writeback data
- flush  in  1  clear all reservations
- dbg_addr  in  ADDR_W  debug read address
- dbg_data  out  DATA_W  debug read data (unbypassed array value)
- busy_any  out  1  at least one counter nonzero

## Operation
- Register 0: reads 0, writes ignored, never reserved, never busy.
- Read port i: rd_data = wr_data if wr_en and wr_addr==rd_addr[i] and rd_addr[i]!=0; else array value. Combinational.
- cnt[r]: CNT_W-bit counter, CNT_W = clog2(MAX_PENDING+1).
- rd_busy[i] = cnt[a]>1, or cnt[a]==1 and not (wr_en and wr_addr==a); a = rd_addr[i], a!=0. A final pending write landing this cycle is covered by bypass.
- Hazard condition: any i with rd_used[i] and rd_busy[i], or iss_dest!=0 and cnt[iss_dest]==MAX_PENDING with no same-cycle release of iss_dest.
- iss_accept = iss_valid and not hazard; stall = iss_valid and hazard.
- Counter update per register r on negedge:
  - Increment when iss_accept and iss_dest==r.
  - Decrement when wr_en and wr_addr==r.
  - Both together: unchanged.
  - Decrement at 0: ignored, no underflow.
  - Increment at MAX_PENDING: unreachable by construction.
- flush: all counters to 0 on that edge, overriding issue and release. The array write in the same cycle still happens. Releases arriving after a flush hit 0 and are ignored.
- Array write on negedge when wr_en and wr_addr!=0.

## Timing
- Reads, bypass, rd_busy, stall, iss_accept, busy_any: combinational, same cycle.
- Write visible in the array from the cycle after the edge; visible via bypass in the same cycle.
- Reservation visible (rd_busy) from the cycle after iss_accept.
- Reset (asynchronous, any time, including mid-stall): all registers 0, all counters 0. Outputs settle to rd_data=0, rd_busy=0, iss_accept=iss_valid, stall=0, dbg_data=0, busy_any=0.
- Stall depth: no limit; stall persists until the blocking reservation is released.

## Structure
- Shared package: DATA_W, ADDR_W, NUM_READ, MAX_PENDING defaults, CNT_W derivation, and the port-slice helper.
- Sub-module scoreboard_cnt: one saturating up/down counter with inc, dec and clr inputs and a cnt output. Instantiated 2**ADDR_W-1 times in a generate loop; register 0 has none.
- Data array: flat reg array in the top module.

## Test plan
- Reset, then read all ports at addresses 0..31: rd_data=0, rd_busy=0, busy_any=0. Write 8<=0x1234, then dbg_addr=8: dbg_data=0x1234 the next cycle.
- Issue dest=8 (accept=1); next cycle issue with rd_addr[0]=8, rd_used[0]=1: stall=1. Then wr_en, wr_addr=8, wr_data=0xABCD in the same cycle as that issue: rd_busy[0]=0, rd_data[0]=0xABCD, iss_accept=1.
- Issue dest=5 three times (MAX_PENDING=3): cnt=3, fourth issue to dest 5 stalls. The same fourth issue together with wr_en on 5 is accepted and cnt stays 3.
- Same-cycle issue dest=9 and wr_en 9 with cnt=1: cnt remains 1; rd_busy on 9 is 1 the next cycle.
- rd_used[1]=0 with rd_addr[1] busy: no stall. Write to register 0 with 0xFFFF: reads of 0 return 0; issue dest=0 leaves busy_any=0.
- Reserve 3 and 7, assert flush: busy_any=0 next cycle. A later wr_en to 3 writes data, leaves cnt at 0, and raises no underflow. Assert SYS_reset mid-stall: stall drops immediately and all counters read 0.
